dmem_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_lane_merge.sv | 47 ++++
 rtl/dmem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
// DMEM_HOST_PORT_EN adds the HOST_RD state used by the optional host port.
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

`ifdef DMEM_HOST_PORT_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RMW_WR  = 2'd2,
    HOST_RD = 2'd3
  } dmem_state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RMW_WR  = 2'd2
  } dmem_state_t;
`endif

  // Encoding 11 is folded into WORD so the core never sees an illegal size.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   decode_size = BYTE;
      2'b01:   decode_size = HALF;
      default: decode_size = WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] off);
    case (sz)
      HALF:    is_misaligned = off[0];
      WORD:    is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane datapath: store merge into an old word and load lane select/extend.
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    merged = rd_word;
    case (size)
      BYTE: begin
        case (off)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      HALF: begin
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  always_comb begin
    byte_v    = rd_word[{off, 3'b000} +: 8];
    half_v    = off[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (size)
      BYTE:    load_data = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      HALF:    load_data = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_data = rd_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: core byte/half/word access to a one-cycle-latency BRAM,
// sub-word stores by read-modify-write. DMEM_HOST_PORT_EN adds a starvation-guarded host port.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_valid,
  input  logic              core_req_we,
  input  logic [1:0]        core_req_size,
  input  logic              core_req_unsigned,
  input  logic [31:0]       core_req_addr,
  input  logic [31:0]       core_req_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  output logic              core_misalign,
`ifdef DMEM_HOST_PORT_EN
  input  logic              host_req_valid,
  input  logic              host_req_we,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [31:0]       host_req_wdata,
  output logic              host_req_ready,
  output logic              host_rvalid,
  output logic [31:0]       host_rdata,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output dmem_state_t       dbg_state
);

  // Handshake: the core holds its request stable while core_stall=1 and the request
  // completes on the first rising edge with core_stall=0; the host request is taken
  // on any edge where host_req_ready=1.

  dmem_state_t       state, state_n;
  mem_size_t         sz;
  logic              misalign;
  logic [ADDR_W-1:0] core_waddr;
  logic [31:0]       merged, load_data, rdata_q;
  logic              host_grant;
  logic              unused_addr_hi;

  assign sz             = decode_size(core_req_size);
  assign misalign       = is_misaligned(sz, core_req_addr[1:0]);
  assign core_waddr     = core_req_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^core_req_addr[31:ADDR_W+2];
  assign dbg_state      = state;

  // Outputs are gated with rst_n so nothing reaches the BRAM while reset is held.
  assign core_misalign  = rst_n && core_req_valid && misalign;

  dmem_lane_merge u_lane (
    .size        (sz),
    .off         (core_req_addr[1:0]),
    .is_unsigned (core_req_unsigned),
    .rd_word     (mem_rdata),
    .wdata       (core_req_wdata),
    .merged      (merged),
    .load_data   (load_data)
  );

`ifdef DMEM_HOST_PORT_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_C = SCW'(STARVE_MAX);

  logic [SCW-1:0] starve_cnt;
  logic [31:0]    host_rdata_q;

  assign host_grant = rst_n && (state == IDLE) && host_req_valid &&
                      (!core_req_valid || starve_cnt == STARVE_C);
  assign host_rdata = host_rvalid ? mem_rdata : host_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt   <= '0;
      host_rdata_q <= '0;
    end else begin
      if (!host_req_valid || host_grant) starve_cnt <= '0;
      else if (starve_cnt != STARVE_C)   starve_cnt <= starve_cnt + SCW'(1);
      if (host_rvalid) host_rdata_q <= mem_rdata;
    end
  end
`else
  assign host_grant = 1'b0;
`endif

  assign core_rdata = core_rvalid ? load_data : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (core_rvalid) rdata_q <= load_data;
    end
  end

  always_comb begin
    state_n     = state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = core_waddr;
    mem_wdata   = core_req_wdata;
    core_stall  = 1'b0;
    core_rvalid = 1'b0;
`ifdef DMEM_HOST_PORT_EN
    host_req_ready = 1'b0;
    host_rvalid    = 1'b0;
`endif
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (host_grant) begin
`ifdef DMEM_HOST_PORT_EN
            host_req_ready = 1'b1;
            mem_en         = 1'b1;
            mem_we         = host_req_we;
            mem_addr       = host_req_addr;
            mem_wdata      = host_req_wdata;
            core_stall     = core_req_valid && !misalign;
            if (!host_req_we) state_n = HOST_RD;
`endif
          end else if (core_req_valid && !misalign) begin
            mem_en = 1'b1;
            if (core_req_we && sz == WORD) begin
              mem_we = 1'b1;
            end else begin
              // Loads and sub-word stores both start with a read of the target word.
              core_stall = 1'b1;
              state_n    = core_req_we ? RMW_WR : LD_WAIT;
            end
          end
        end
        LD_WAIT: begin
          core_rvalid = 1'b1;
          state_n     = IDLE;
        end
        RMW_WR: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = merged;
          state_n   = IDLE;
        end
`ifdef DMEM_HOST_PORT_EN
        HOST_RD: begin
          host_rvalid = 1'b1;
          core_stall  = core_req_valid && !misalign;
          state_n     = IDLE;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: reset checks, table of core accesses against a BRAM model,
// reset during RMW, and (with DMEM_HOST_PORT_EN) the host starvation guard.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              core_req_valid = 1'b0;
  logic              core_req_we = 1'b0;
  logic [1:0]        core_req_size = 2'b00;
  logic              core_req_unsigned = 1'b0;
  logic [31:0]       core_req_addr = '0;
  logic [31:0]       core_req_wdata = '0;
  logic              core_stall, core_rvalid, core_misalign;
  logic [31:0]       core_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  dmem_state_t       dbg_state;
`ifdef DMEM_HOST_PORT_EN
  logic              host_req_valid = 1'b0;
  logic              host_req_we = 1'b0;
  logic [ADDR_W-1:0] host_req_addr = '0;
  logic [31:0]       host_req_wdata = '0;
  logic              host_req_ready, host_rvalid;
  logic [31:0]       host_rdata;
`endif

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_stall;
    logic        exp_mis;
    logic        chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[21];

  dmem_ctrl #(.ADDR_W(ADDR_W), .STARVE_MAX(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_req_valid    (core_req_valid),
    .core_req_we       (core_req_we),
    .core_req_size     (core_req_size),
    .core_req_unsigned (core_req_unsigned),
    .core_req_addr     (core_req_addr),
    .core_req_wdata    (core_req_wdata),
    .core_stall        (core_stall),
    .core_rvalid       (core_rvalid),
    .core_rdata        (core_rdata),
    .core_misalign     (core_misalign),
`ifdef DMEM_HOST_PORT_EN
    .host_req_valid    (host_req_valid),
    .host_req_we       (host_req_we),
    .host_req_addr     (host_req_addr),
    .host_req_wdata    (host_req_wdata),
    .host_req_ready    (host_req_ready),
    .host_rvalid       (host_rvalid),
    .host_rdata        (host_rdata),
`endif
    .mem_en            (mem_en),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .dbg_state         (dbg_state)
  );

  // clock / BRAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // scoreboard: load results pop in order as core_rvalid appears
  always @(negedge clk) begin
    if (rst_n && core_rvalid) begin
      if (exp_q.size() == 0) check("load_unexpected", core_rdata, 32'hxxxxxxxx);
      else check("load_data", core_rdata, exp_q.pop_front());
    end
  end

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int st, input logic mis,
                              input logic cm, input logic [31:0] em);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd; v.exp_rd = rd;
    v.exp_stall = st; v.exp_mis = mis; v.chk_mem = cm; v.exp_mem = em;
    return v;
  endfunction

  task automatic core_op(input vec_t v, input int idx);
    int n;
    n = 0;
    @(posedge clk); #1;
    core_req_valid = 1'b1; core_req_we = v.we; core_req_size = v.size;
    core_req_unsigned = v.uns; core_req_addr = v.addr; core_req_wdata = v.wdata;
    if (!v.we && !v.exp_mis) exp_q.push_back(v.exp_rd);
    @(negedge clk);
    check($sformatf("misalign[%0d]", idx), {31'b0, core_misalign}, {31'b0, v.exp_mis});
    if (v.exp_mis) check($sformatf("mis_mem_en[%0d]", idx), {31'b0, mem_en}, 32'd0);
    while (core_stall && n < 10) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("stall_cycles[%0d]", idx), n, v.exp_stall);
    @(posedge clk); #1;
    core_req_valid = 1'b0;
    if (v.chk_mem)
      check($sformatf("mem_word[%0d]", idx), mem[v.addr[ADDR_W+1:2]], v.exp_mem);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    //          we    sz     uns   addr          wdata         exp_rd        st mis   chk   exp_mem
    vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        0, 1'b0, 1'b1, 32'hDEADBEEF);
    vecs[1]  = mk(1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1, 1'b0, 1'b0, 32'h0);
    vecs[2]  = mk(1'b1, 2'b10, 1'b0, 32'h20,       32'h11223344, 32'h0,        0, 1'b0, 1'b1, 32'h11223344);
    vecs[3]  = mk(1'b1, 2'b00, 1'b0, 32'h22,       32'h000000AA, 32'h0,        1, 1'b0, 1'b1, 32'h11AA3344);
    vecs[4]  = mk(1'b0, 2'b00, 1'b0, 32'h22,       32'h0,        32'hFFFFFFAA, 1, 1'b0, 1'b0, 32'h0);
    vecs[5]  = mk(1'b0, 2'b00, 1'b1, 32'h22,       32'h0,        32'h000000AA, 1, 1'b0, 1'b0, 32'h0);
    vecs[6]  = mk(1'b1, 2'b10, 1'b0, 32'h24,       32'h0,        32'h0,        0, 1'b0, 1'b1, 32'h0);
    vecs[7]  = mk(1'b1, 2'b01, 1'b0, 32'h26,       32'h00008001, 32'h0,        1, 1'b0, 1'b1, 32'h80010000);
    vecs[8]  = mk(1'b0, 2'b01, 1'b0, 32'h26,       32'h0,        32'hFFFF8001, 1, 1'b0, 1'b0, 32'h0);
    vecs[9]  = mk(1'b0, 2'b01, 1'b1, 32'h26,       32'h0,        32'h00008001, 1, 1'b0, 1'b0, 32'h0);
    vecs[10] = mk(1'b0, 2'b10, 1'b0, 32'h13,       32'h0,        32'h0,        0, 1'b1, 1'b1, 32'hDEADBEEF);
    vecs[11] = mk(1'b0, 2'b01, 1'b0, 32'h21,       32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0);
    vecs[12] = mk(1'b1, 2'b10, 1'b0, 32'h22,       32'h12345678, 32'h0,        0, 1'b1, 1'b1, 32'h11AA3344);
    vecs[13] = mk(1'b0, 2'b00, 1'b0, 32'h21,       32'h0,        32'h00000033, 1, 1'b0, 1'b0, 32'h0);
    vecs[14] = mk(1'b0, 2'b01, 1'b0, 32'h20,       32'h0,        32'h00003344, 1, 1'b0, 1'b0, 32'h0);
    vecs[15] = mk(1'b1, 2'b00, 1'b0, 32'h13,       32'h0000007F, 32'h0,        1, 1'b0, 1'b1, 32'h7FADBEEF);
    vecs[16] = mk(1'b1, 2'b11, 1'b0, 32'h30,       32'hCAFEF00D, 32'h0,        0, 1'b0, 1'b1, 32'hCAFEF00D);
    vecs[17] = mk(1'b0, 2'b11, 1'b0, 32'h30,       32'h0,        32'hCAFEF00D, 1, 1'b0, 1'b0, 32'h0);
    vecs[18] = mk(1'b0, 2'b10, 1'b0, 32'h00010010, 32'h0,        32'h7FADBEEF, 1, 1'b0, 1'b0, 32'h0);
    vecs[19] = mk(1'b0, 2'b00, 1'b0, 32'h12,       32'h0,        32'hFFFFFFAD, 1, 1'b0, 1'b0, 32'h0);
    vecs[20] = mk(1'b1, 2'b01, 1'b0, 32'h20,       32'hFFFF1234, 32'h0,        1, 1'b0, 1'b1, 32'h11AA1234);

    // reset with a live core request: every output must stay low
    core_req_valid = 1'b1; core_req_addr = 32'h10; core_req_size = 2'b10;
    repeat (2) @(negedge clk);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_stall", {31'b0, core_stall}, 32'd0);
    check("rst_rvalid", {31'b0, core_rvalid}, 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
`ifdef DMEM_HOST_PORT_EN
    check("rst_host_ready", {31'b0, host_req_ready}, 32'd0);
    check("rst_host_rvalid", {31'b0, host_rvalid}, 32'd0);
    check("rst_host_rdata", host_rdata, 32'd0);
`endif
    @(posedge clk); #1;
    core_req_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) core_op(vecs[i], i);

    // rdata holds after the last load while rvalid is low
    @(negedge clk);
    check("rdata_hold", core_rdata, 32'hFFFFFFAD);

    // reset asserted in the RMW_WR cycle aborts the write
    core_op(mk(1'b1, 2'b10, 1'b0, 32'h40, 32'h55667788, 32'h0, 0, 1'b0, 1'b1, 32'h55667788), 100);
    @(posedge clk); #1;
    core_req_valid = 1'b1; core_req_we = 1'b1; core_req_size = 2'b00;
    core_req_addr = 32'h41; core_req_wdata = 32'h99;
    @(posedge clk); #1;
    check("rmw_state", {30'b0, dbg_state}, {30'b0, RMW_WR});
    rst_n = 1'b0;
    core_req_valid = 1'b0;
    #1;
    check("rmw_rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rmw_rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rmw_rst_rdata", core_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rmw_abort_mem", mem[16], 32'h55667788);
    check("rmw_abort_state", {30'b0, dbg_state}, {30'b0, IDLE});

`ifdef DMEM_HOST_PORT_EN
    begin
      int denied;
      bit granted;
      // host write with an idle core is granted at once
      @(posedge clk); #1;
      host_req_valid = 1'b1; host_req_we = 1'b1; host_req_addr = 10'd20; host_req_wdata = 32'h0BADF00D;
      @(negedge clk);
      check("host_wr_ready", {31'b0, host_req_ready}, 32'd1);
      @(posedge clk); #1;
      host_req_valid = 1'b0;
      check("host_wr_mem", mem[20], 32'h0BADF00D);

      // host read against back-to-back core loads: forced grant after 8 denials
      host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 10'd20;
      core_req_valid = 1'b1; core_req_we = 1'b0; core_req_size = 2'b10;
      core_req_unsigned = 1'b0; core_req_addr = 32'h10;
      denied = 0;
      granted = 1'b0;
      for (int c = 0; c < 30 && !granted; c++) begin
        @(negedge clk);
        if (host_req_ready) begin
          granted = 1'b1;
          check("grant_core_stall", {31'b0, core_stall}, 32'd1);
        end else begin
          denied++;
          if (mem_en && !mem_we) exp_q.push_back(32'h7FADBEEF);
        end
      end
      check("host_granted", {31'b0, granted}, 32'd1);
      check("host_denied_cycles", denied, 32'd8);
      @(posedge clk); #1;
      host_req_valid = 1'b0;
      @(negedge clk);
      check("host_rvalid", {31'b0, host_rvalid}, 32'd1);
      check("host_rdata", host_rdata, 32'h0BADF00D);
      check("host_rd_core_stall", {31'b0, core_stall}, 32'd1);
      @(posedge clk); #1;
      core_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("host_rdata_hold", host_rdata, 32'h0BADF00D);
    end
`endif

    repeat (3) @(posedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
